// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = div_cnt_w(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] QUOT_DIVZ = '1;

endpackage

// File: rtl/div_addsub_step.sv
// One non-restoring step: P + (D ^ {sub}) + sub, i.e. P-D when sub=1, P+D when sub=0.
module div_addsub_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] i_p,
  input  logic [WIDTH:0] i_d,
  input  logic           i_sub,
  output logic [WIDTH:0] o_p,
  output logic           o_qbit
);

  logic [WIDTH:0] w_d_cond;

  assign w_d_cond = i_d ^ {(WIDTH + 1){i_sub}};
  assign o_p      = i_p + w_d_cond + {{WIDTH{1'b0}}, i_sub};
  assign o_qbit   = ~o_p[WIDTH];

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle non-restoring divider with start/done handshake.
// Signed operation (is_signed port) is compiled in only with DIV_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one add/sub iteration per cycle, WIDTH cycles
// FIX   | remainder correction, result sign fix-up and load
// DONE  | done pulse for one cycle
module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int ITER = WIDTH;
  localparam int CW   = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  div_state_e       r_state, w_next;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_dbz, r_neg_q, r_neg_r;

  logic             w_sgn, w_a_neg, w_b_neg, w_fix, w_sub, w_qbit;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_step_p, w_new_p, w_p_fix;

`ifdef DIV_SIGNED_EN
  assign w_sgn = is_signed;
`else
  assign w_sgn = 1'b0;
`endif

  assign w_a_neg = w_sgn & dividend[WIDTH-1];
  assign w_b_neg = w_sgn & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? -dividend : dividend;
  assign w_b_mag = w_b_neg ? -divisor : divisor;

  // The single adder serves both RUN (shifted P, sign-selected op) and FIX (plain P+D).
  assign w_fix    = (r_state == FIX);
  assign w_step_p = w_fix ? r_p : {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sub    = w_fix ? 1'b0 : ~r_p[WIDTH];
  assign w_p_fix  = r_p[WIDTH] ? w_new_p : r_p;

  div_addsub_step #(.WIDTH(WIDTH)) u_step (
    .i_p    (w_step_p),
    .i_d    ({1'b0, r_d}),
    .i_sub  (w_sub),
    .o_p    (w_new_p),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = (divisor == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_next = FIX;
      end
      FIX: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_p     <= '0;
          r_q     <= w_a_mag;
          r_d     <= w_b_mag;
          r_cnt   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          if (divisor == '0) begin
            r_quot <= '1;
            r_rem  <= dividend;
            r_dbz  <= 1'b1;
          end
        end
        RUN: begin
          r_p   <= w_new_p;
          r_q   <= {r_q[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_p    <= w_p_fix;
          r_quot <= r_neg_q ? -r_q : r_q;
          r_rem  <= r_neg_r ? -w_p_fix[WIDTH-1:0] : w_p_fix[WIDTH-1:0];
          r_dbz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: directed boundaries, handshake cases and random operands.
module tb_alu_div_seq;

  localparam int W   = 32;
  localparam int LAT = W + 1;  // edges after the start edge until done is seen

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  dividend, divisor;
`ifdef DIV_SIGNED_EN
  logic          is_signed;
`endif
  logic          busy, done, div_by_zero;
  logic [W-1:0]  quotient, remainder;

  int checks = 0;
  int errors = 0;

  alu_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic wait_done(inout int k, input string tag);
    while (done !== 1'b1 && k < LAT + 10) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    logic [31:0] eq, er;
    int k, lat;
    model(a, b, sgn, eq, er);
    lat = (b == 32'd0) ? 0 : LAT;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    is_signed = sgn;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    wait_done(k, tag);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, k, lat);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(b == 32'd0));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " q_held"}, quotient, eq);
  endtask

  initial begin
    int k, ndone;
    logic [31:0] a, b;
    logic sgn;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    chk("rst dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, "100/7");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "max/1");
    run_op(32'd5, 32'd0, 1'b0, "5/0");
    run_op(32'd0, 32'd12345, 1'b0, "0/x");
    run_op(32'd12, 32'd1000, 1'b0, "a<b");
    run_op(32'hDEAD_BEEF, 32'd1, 1'b0, "x/1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max/max");
    run_op(32'h8000_0000, 32'h8000_0001, 1'b0, "big a<b");
    run_op(32'hFFFF_FFFE, 32'h8000_0000, 1'b0, "big/big");

    // start while busy must be ignored
    dividend = 32'd1000;
    divisor  = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    repeat (9) begin
      @(posedge clk); #1;
      k++;
    end
    dividend = 32'd9;
    divisor  = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k++;
    wait_done(k, "ignored");
    chk("ignored done", 32'(done), 32'd1);
    chk("ignored latency", k, LAT);
    chk("ignored quotient", quotient, 32'd333);
    chk("ignored remainder", remainder, 32'd1);
    @(posedge clk); #1;

    // reset mid-operation aborts without a done
    dividend = 32'd1000;
    divisor  = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort no_done", ndone, 0);
    run_op(32'd9, 32'd3, 1'b0, "after_abort");

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s -7/2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s ovf");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s 7/-2");
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, "s -7/0");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, "u -7/2");
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: begin
          a = $urandom_range(0, 100000);
          b = $urandom | 32'h8000_0000;
        end
        default: b = $urandom_range(0, 3);
      endcase
`ifdef DIV_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      run_op(a, b, sgn, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle unsigned (optionally signed) 32-bit divider for the ALU datapath.
- Implements non-restoring division: each iteration either adds or subtracts the divisor, selected by the sign of the partial remainder.
- This is the consumer side of the ALU's XOR-based add/sub operand conditioning.
- Sits beside the combinational adder; the ALU controller launches it with a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ITER, WIDTH, number of iteration cycles. Fixed equal to WIDTH; not overridable independently.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- dividend  in  WIDTH  numerator; captured on an accepted start.
- divisor  in  WIDTH  denominator; captured on an accepted start.
- is_signed  in  1  signed-operation select; present only with DIV_SIGNED_EN.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; quotient/remainder are valid in that cycle.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- div_by_zero  out  1  set alongside done when divisor==0; held with the results.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers P (WIDTH+1 bits, signed partial remainder), Q, D and the iteration counter are cleared.
  - rst during RUN or FIX aborts the operation; no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge T captures the operands, P=0, Q=dividend, counter=0.
  - If divisor!=0: go to RUN.
  - If divisor==0: go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE; outputs hold.
- RUN (one iteration per cycle, ITER cycles):
  - Shift {P,Q} left by 1.
  - If old P[WIDTH]==0: P=P-D, implemented as add of ~D with carry-in 1. Otherwise P=P+D.
  - Shifted-in Q LSB = ~new P[WIDTH].
  - Counter increments; after ITER iterations go to FIX.
  - Add/sub control is a single bit per cycle; no restore cycle.
- FIX (1 cycle):
  - If P[WIDTH]==1 then P=P+D (remainder correction).
  - Load quotient=Q, remainder=P[WIDTH-1:0]; go to DONE.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- Latency:
  - divisor!=0: done is high in the cycle starting at edge T+ITER+2 (T+34 at WIDTH=32).
  - divisor==0: done is high at T+1.
  - busy is high from T+1 through the cycle before done.
- Handshake:
  - start while busy or in DONE is ignored; no queuing.
  - start may be asserted in the same cycle the FSM returns to IDLE and is accepted.
  - done never coincides with busy.
- Arithmetic:
  - P is WIDTH+1 bits so the sign bit is never lost.
  - D is zero-extended to WIDTH+1.
  - All sums wrap modulo 2^(WIDTH+1).
- Boundaries:
  - dividend < divisor: quotient=0, remainder=dividend.
  - dividend==0: quotient=0, remainder=0.
  - divisor==1: quotient=dividend, remainder=0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - is_signed port exists.
  - With is_signed=1, operands are converted to magnitudes at capture.
  - In FIX, quotient is negated if the operand signs differ, and remainder takes the dividend's sign.
  - No extra latency.
  - Overflow -2^31/-1 gives quotient=0x80000000, remainder=0.
  - Divide-by-zero behaves as unsigned: quotient=all ones, remainder=dividend.
- Undefined: the is_signed port is absent and all operations are unsigned.

Decomposition:
- Package alu_div_pkg holds:
  - WIDTH default constant.
  - State enum {IDLE, RUN, FIX, DONE}.
  - Counter width constant $clog2(WIDTH+1).
  - All-ones quotient constant for divide-by-zero.
- Sub-module div_addsub_step: combinational.
  - Inputs P, D, sub (sub = ~P[WIDTH]).
  - Conditions D by XOR with sub, adds with carry-in=sub.
  - Outputs the new P and the quotient bit.
  - Instantiated once and reused by FIX with sub=0.

Test Plan:
- 100/7, start at T -> done at T+34; quotient=14, remainder=2, div_by_zero=0; busy high T+1..T+33.
- 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- 5/0 -> done at T+1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; busy never asserted.
- 1000/3 started, then start pulsed with 9/3 at T+10 -> second start ignored; result quotient=333, remainder=1.
- 1000/3 started, rst at T+15, then 9/3 started -> no done from the first operation; second gives quotient=3, remainder=0.
- DIV_SIGNED_EN, is_signed=1:
  - -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
